// File: rtl/note_rec_pkg.sv
// Shared types and helpers for the note event recorder.
//   note_evt_t : note record {key, start, dur} at default widths
//   KEY_NONE   : key index meaning "no key"
//   tick_div   : clock cycles per time-base tick (never below 1)
package note_rec_pkg;

  localparam int unsigned KEY_NONE   = 0;
  localparam int unsigned DEF_KEY_W  = 2;
  localparam int unsigned DEF_TIME_W = 14;
  localparam int unsigned DEF_DUR_W  = 8;

  typedef struct packed {
    logic [DEF_KEY_W-1:0]  key;
    logic [DEF_TIME_W-1:0] start;
    logic [DEF_DUR_W-1:0]  dur;
  } note_evt_t;

  function automatic int unsigned tick_div(input int unsigned clk_hz, input int unsigned tick_hz);
    int unsigned d;
    d = clk_hz / tick_hz;
    if (d == 0) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/note_event_recorder_if.sv
// Note record stream: producer (master) presents the FIFO head, consumer
// (slave) accepts it with evt_ready.
//   evt_valid/evt_key/evt_start/evt_dur : master -> slave
//   evt_ready                           : slave -> master
interface note_event_recorder_if #(
  parameter int unsigned KEY_W  = 2,
  parameter int unsigned TIME_W = 14,
  parameter int unsigned DUR_W  = 8
);
  logic              evt_valid;
  logic              evt_ready;
  logic [KEY_W-1:0]  evt_key;
  logic [TIME_W-1:0] evt_start;
  logic [DUR_W-1:0]  evt_dur;

  modport master (output evt_valid, evt_key, evt_start, evt_dur, input evt_ready);
  modport slave  (input evt_valid, evt_key, evt_start, evt_dur, output evt_ready);
endinterface

// File: rtl/note_event_fifo.sv
// Synchronous show-ahead FIFO of note records.
//   push/wr_data : enqueue (accepted when not full, or when popping)
//   pop/rd_data  : rd_data is the head whenever !empty, zero otherwise
//   clear        : synchronous flush
//   count/full/empty : occupancy
module note_event_fifo
  import note_rec_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter type T = note_evt_t
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       push,
  input  T                           wr_data,
  input  logic                       pop,
  output T                           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // when full, a simultaneous pop frees the slot the push writes into
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign rd_data = empty ? T'('0) : mem[rd_ptr];

  // storage
  always_ff @(posedge clock) begin
    if (push_ok && !clear) mem[wr_ptr] <= wr_data;
  end

  // pointers and occupancy
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/note_event_recorder.sv
// Multi-key note recorder: synchronises and debounces active-low keys,
// timestamps presses on a tick time base and queues {key, start, dur}
// records on release for a valid/ready consumer.
//   clock, reset_n   : clock, async active-low reset
//   key_n            : raw active-low buttons
//   clear            : synchronous soft clear (debounced state retained)
//   evt              : record stream (master)
//   system_time      : tick count, wraps
//   held             : debounced pressed state per key
//   overflow         : sticky, a record was dropped
//   fifo_count       : records queued
module note_event_recorder
  import note_rec_pkg::*;
#(
  parameter int unsigned NUM_KEYS       = 3,
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned TICK_HZ        = 100,
  parameter int unsigned TIME_W         = 14,
  parameter int unsigned DUR_W          = 8,
  parameter int unsigned DEBOUNCE_TICKS = 2,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [NUM_KEYS-1:0]             key_n,
  input  logic                            clear,
  note_event_recorder_if.master           evt,
  output logic [TIME_W-1:0]               system_time,
  output logic [NUM_KEYS-1:0]             held,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int unsigned KEY_W   = $clog2(NUM_KEYS + 1);
  localparam int unsigned DIV     = tick_div(CLK_HZ, TICK_HZ);
  localparam int unsigned TCNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned DUR_MAX = (1 << DUR_W) - 1;

  typedef struct packed {
    logic [KEY_W-1:0]  key;
    logic [TIME_W-1:0] start;
    logic [DUR_W-1:0]  dur;
  } rec_t;

  logic [TCNT_W-1:0] tick_cnt;
  logic              tick_c;
  logic [NUM_KEYS-1:0] key_s1;
  logic [NUM_KEYS-1:0] key_s2;
  logic [NUM_KEYS-1:0] pressed_s;
  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] grant;
  logic [TIME_W-1:0]   rec_start [NUM_KEYS];
  logic [DUR_W-1:0]    rec_dur   [NUM_KEYS];
  rec_t                push_rec;
  rec_t                head;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;

  // tick generator and system time
  assign tick_c = (tick_cnt == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt    <= '0;
      system_time <= '0;
    end else if (clear) begin
      tick_cnt    <= '0;
      system_time <= '0;
    end else begin
      tick_cnt <= tick_c ? TCNT_W'(DIV - 1) : tick_cnt - TCNT_W'(1);
      if (tick_c) system_time <= system_time + TIME_W'(1);
    end
  end

  // two-flop synchroniser; idle level is released (high)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_s1 <= '1;
      key_s2 <= '1;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
    end
  end

  assign pressed_s = ~key_s2;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic [DB_W-1:0]   db_cnt;
    logic              stable;
    logic              held_d;
    logic [TIME_W-1:0] start_q;
    logic              pend;
    logic [TIME_W-1:0] r_start;
    logic [DUR_W-1:0]  r_dur;
    logic [TIME_W-1:0] diff;

    assign diff         = system_time - start_q;
    assign held[k]      = stable;
    assign pending[k]   = pend;
    assign rec_start[k] = r_start;
    assign rec_dur[k]   = r_dur;

    // debouncer: flip only after DEBOUNCE_TICKS consecutive differing ticks
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        db_cnt <= '0;
        stable <= 1'b0;
        held_d <= 1'b0;
      end else begin
        held_d <= stable;
        if (tick_c) begin
          if (pressed_s[k] != stable) begin
            if (db_cnt == DB_W'(DEBOUNCE_TICKS - 1)) begin
              stable <= pressed_s[k];
              db_cnt <= '0;
            end else begin
              db_cnt <= db_cnt + DB_W'(1);
            end
          end else begin
            db_cnt <= '0;
          end
        end
      end
    end

    // press timestamp and pending release record
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        start_q <= '0;
        pend    <= 1'b0;
        r_start <= '0;
        r_dur   <= '0;
      end else if (clear) begin
        start_q <= '0;
        pend    <= 1'b0;
        r_start <= '0;
        r_dur   <= '0;
      end else begin
        if (stable && !held_d) start_q <= system_time;
        if (!stable && held_d) begin
          pend    <= 1'b1;
          r_start <= start_q;
          r_dur   <= (32'(diff) > DUR_MAX) ? DUR_W'(DUR_MAX) : DUR_W'(diff);
        end else if (grant[k]) begin
          pend <= 1'b0;
        end
      end
    end
  end

  // arbiter: lowest-index pending key wins
  always_comb begin
    logic found;
    found        = 1'b0;
    grant        = '0;
    push_rec     = '0;
    push_rec.key = KEY_W'(KEY_NONE);
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      if (pending[k] && !found) begin
        found          = 1'b1;
        grant[k]       = 1'b1;
        push_rec.key   = KEY_W'(k + 1);
        push_rec.start = rec_start[k];
        push_rec.dur   = rec_dur[k];
      end
    end
  end

  assign push = |pending;
  assign pop  = !fifo_empty && evt.evt_ready;

  note_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (rec_t)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (push),
    .wr_data (push_rec),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_key   = head.key;
  assign evt.evt_start = head.start;
  assign evt.evt_dur   = head.dur;

  // sticky drop flag: full with no pop frees nothing
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_note_event_recorder.sv
module tb_note_event_recorder;

  typedef struct packed {
    logic [1:0]  key;
    logic [13:0] start;
    logic [7:0]  dur;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  key_n0, key_n1;
  logic        clear0, clear1;
  logic        rdy0, rdy1;
  logic [13:0] st0, st1;
  logic [2:0]  held0, held1;
  logic        ovf0, ovf1;
  logic [3:0]  cnt0, cnt1;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   npop0 = 0;
  int   npop1 = 0;
  int   pop_cyc0 [64];
  exp_t exp0 [$];
  exp_t exp1 [$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  note_event_recorder_if #(.KEY_W(2), .TIME_W(14), .DUR_W(8)) bus0 ();
  note_event_recorder_if #(.KEY_W(2), .TIME_W(14), .DUR_W(8)) bus1 ();
  assign bus0.evt_ready = rdy0;
  assign bus1.evt_ready = rdy1;

  note_event_recorder #(
    .NUM_KEYS(3), .CLK_HZ(1000), .TICK_HZ(100), .TIME_W(14), .DUR_W(8),
    .DEBOUNCE_TICKS(2), .FIFO_DEPTH(8)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .key_n(key_n0), .clear(clear0), .evt(bus0),
    .system_time(st0), .held(held0), .overflow(ovf0), .fifo_count(cnt0)
  );

  // fast time base so the 14-bit wrap is reachable
  note_event_recorder #(
    .NUM_KEYS(3), .CLK_HZ(300), .TICK_HZ(100), .TIME_W(14), .DUR_W(8),
    .DEBOUNCE_TICKS(2), .FIFO_DEPTH(8)
  ) u_dut_wrap (
    .clock(clock), .reset_n(reset_n), .key_n(key_n1), .clear(clear1), .evt(bus1),
    .system_time(st1), .held(held1), .overflow(ovf1), .fifo_count(cnt1)
  );

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int cur_time(input int inst);
    return (inst == 0) ? int'(st0) : int'(st1);
  endfunction

  task automatic wait_time(input int inst, input int t);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (cur_time(inst) != t && n < 70000);
    if (n >= 70000) check($sformatf("wait_time_%0d_%0d", inst, t), cur_time(inst), t);
  endtask

  // scoreboard monitors: compare each accepted head against the queue
  initial forever begin
    exp_t e;
    @(negedge clock);
    #1;
    if (bus0.evt_valid && bus0.evt_ready) begin
      if (npop0 < 64) pop_cyc0[npop0] = cyc;
      npop0++;
      if (exp0.size() == 0) begin
        check("mon0_unexpected_key", bus0.evt_key, 0);
        check("mon0_unexpected_rec", 1, 0);
      end else begin
        e = exp0.pop_front();
        check($sformatf("mon0_key_%0d", npop0), bus0.evt_key, e.key);
        check($sformatf("mon0_start_%0d", npop0), bus0.evt_start, e.start);
        check($sformatf("mon0_dur_%0d", npop0), bus0.evt_dur, e.dur);
      end
    end
    if (bus1.evt_valid && bus1.evt_ready) begin
      npop1++;
      if (exp1.size() == 0) begin
        check("mon1_unexpected_rec", 1, 0);
      end else begin
        e = exp1.pop_front();
        check("mon1_key", bus1.evt_key, e.key);
        check("mon1_start", bus1.evt_start, e.start);
        check("mon1_dur", bus1.evt_dur, e.dur);
      end
    end
  end

  task automatic main_seq();
    int t;
    int k;
    // soft clear restarts time at 0
    clear0 = 1'b1;
    @(negedge clock);
    clear0 = 1'b0;

    // single note on key 2
    wait_time(0, 5);
    key_n0[1] = 1'b0;
    exp0.push_back('{key: 2'd2, start: 14'd7, dur: 8'd35});
    wait_time(0, 8);
    check("held_key2", held0, 3'b010);
    wait_time(0, 40);
    key_n0[1] = 1'b1;
    wait_time(0, 45);
    check("pops_after_note", npop0, 1);
    check("held_after_release", held0, 0);

    // one-tick glitch is rejected
    wait_time(0, 50);
    key_n0[0] = 1'b0;
    repeat (8) @(negedge clock);
    key_n0[0] = 1'b1;
    wait_time(0, 55);
    check("glitch_held", held0, 0);
    check("glitch_no_record", npop0, 1);

    // overlapping keys, simultaneous release, press during release
    wait_time(0, 60);
    key_n0[0] = 1'b0;
    wait_time(0, 63);
    key_n0[2] = 1'b0;
    wait_time(0, 66);
    check("held_1_3", held0, 3'b101);
    wait_time(0, 75);
    exp0.push_back('{key: 2'd1, start: 14'd62, dur: 8'd15});
    exp0.push_back('{key: 2'd3, start: 14'd65, dur: 8'd12});
    exp0.push_back('{key: 2'd2, start: 14'd77, dur: 8'd10});
    key_n0[0] = 1'b1;
    key_n0[2] = 1'b1;
    key_n0[1] = 1'b0;
    wait_time(0, 78);
    check("held_swap", held0, 3'b010);
    check("pops_simul", npop0, 3);
    check("simul_consecutive", pop_cyc0[2] - pop_cyc0[1], 1);
    wait_time(0, 85);
    key_n0[1] = 1'b1;
    wait_time(0, 90);
    check("pops_after_swap", npop0, 4);

    // nine notes with consumer stalled
    rdy0 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      k = i % 3;
      t = 100 + 6 * i;
      wait_time(0, t);
      key_n0[k] = 1'b0;
      wait_time(0, t + 4);
      key_n0[k] = 1'b1;
      if (i < 8) exp0.push_back('{key: 2'(k + 1), start: 14'(t + 2), dur: 8'd4});
    end
    wait_time(0, 157);
    check("full_count", cnt0, 8);
    check("overflow_set", ovf0, 1);
    check("stall_head_key", bus0.evt_key, 1);
    check("stall_head_start", bus0.evt_start, 102);
    check("stall_head_dur", bus0.evt_dur, 4);
    check("stall_no_pop", npop0, 4);
    rdy0 = 1'b1;
    wait_time(0, 160);
    check("drained_pops", npop0, 12);
    check("drained_count", cnt0, 0);
    check("overflow_sticky", ovf0, 1);
    clear0 = 1'b1;
    @(negedge clock);
    clear0 = 1'b0;
    check("clear_overflow", ovf0, 0);
    check("clear_count", cnt0, 0);
    check("clear_time", st0, 0);

    // long hold saturates duration
    wait_time(0, 5);
    key_n0[0] = 1'b0;
    exp0.push_back('{key: 2'd1, start: 14'd7, dur: 8'd255});
    wait_time(0, 310);
    key_n0[0] = 1'b1;
    wait_time(0, 315);
    check("pops_long", npop0, 13);
    check("count_long", cnt0, 0);
  endtask

  task automatic wrap_seq();
    wait_time(1, 16380);
    key_n1[0] = 1'b0;
    exp1.push_back('{key: 2'd1, start: 14'd16382, dur: 8'd9});
    wait_time(1, 5);
    key_n1[0] = 1'b1;
    wait_time(1, 12);
    check("pops_wrap", npop1, 1);
  endtask

  initial begin
    reset_n = 1'b0;
    key_n0  = '1;
    key_n1  = '1;
    clear0  = 1'b0;
    clear1  = 1'b0;
    rdy0    = 1'b1;
    rdy1    = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_time", st0, 0);
    check("rst_valid", bus0.evt_valid, 0);
    check("rst_key", bus0.evt_key, 0);
    check("rst_start", bus0.evt_start, 0);
    check("rst_dur", bus0.evt_dur, 0);
    check("rst_held", held0, 0);
    check("rst_overflow", ovf0, 0);
    check("rst_count", cnt0, 0);
    reset_n = 1'b1;
    repeat (200) @(posedge clock);
    @(negedge clock);
    check("time_200", st0, 20);
    check("idle_valid", bus0.evt_valid, 0);
    check("idle_held", held0, 0);
    check("idle_count", cnt0, 0);

    fork
      main_seq();
      wrap_seq();
    join

    repeat (5) @(negedge clock);
    check("exp0_left", exp0.size(), 0);
    check("exp1_left", exp1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_event_recorder.md
# note_event_recorder

Parametrised multi-key note recorder for the piano front end. Converts NUM_KEYS raw active-low push-buttons into debounced press/release events, timestamps each press against a free-running tick-based system time, and on release queues a complete note record (key index, start time, duration) into an internal FIFO. Downstream playback and storage logic drains the records over a valid/ready handshake.

## Interface
- NUM_KEYS, 3: number of key inputs (1..15).
- CLK_HZ, 50_000_000: clock frequency.
- TICK_HZ, 100: time-base rate; one tick = 0.01 s at default.
- TIME_W, 14: system_time / start-time width (wraps).
- DUR_W, 8: duration width (saturates).
- DEBOUNCE_TICKS, 2: consecutive ticks a level change must persist.
- FIFO_DEPTH, 8: event FIFO depth (power of 2, ≥2).
- clock  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- key_n  in  NUM_KEYS  raw buttons, active-low, asynchronous.
- clear  in  1  synchronous soft clear.
- evt_valid  out  1  FIFO head holds a record.
- evt_ready  in  1  consumer accepts head.
- evt_key  out  KEY_W=$clog2(NUM_KEYS+1)  key index 1..NUM_KEYS; 0 = no key.
- evt_start  out  TIME_W  press timestamp (ticks).
- evt_dur  out  DUR_W  hold duration (ticks).
- system_time  out  TIME_W  current time (ticks).
- held  out  NUM_KEYS  debounced pressed state per key.
- overflow  out  1  sticky: a record was dropped.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  records queued.

## Operation
- Tick generator: down-counter loaded with CLK_HZ/TICK_HZ-1; tick pulses one cycle when it reaches 0 and reloads. system_time increments on tick, wraps mod 2^TIME_W.
- Each key_n bit passes a 2-flop synchroniser, then a per-key debouncer: counter samples on tick; stable state flips only after DEBOUNCE_TICKS consecutive ticks of differing level; any agreeing sample resets the counter.
- Debounced press (held 0→1): capture system_time into that key's own start register. Keys are fully independent; overlapping presses keep separate start times.
- Debounced release (1→0): dur = (system_time − start) mod 2^TIME_W, saturated to 2^DUR_W−1; set per-key pending bit with {key index, start, dur}.
- Arbiter: each cycle, lowest-index pending key is pushed into FIFO and its pending bit cleared. If FIFO full and no pop that cycle, record dropped, pending cleared, overflow set.
- FIFO show-ahead: evt_* reflect head whenever evt_valid=1; pop when evt_valid && evt_ready. Push and pop in the same cycle are both honoured, including when full.
- clear: synchronous; zeroes tick counter, system_time, start registers, pending bits, FIFO, overflow; debouncer stable states and held are retained (a key held across clear reports start 0).

## Timing
- All outputs 0 in reset: evt_valid, evt_key, evt_start, evt_dur, system_time, held, overflow, fifo_count.
- Reset asserted mid-operation: immediate return to above; in-flight and queued records lost.
- key_n edge → held change: 2 synchroniser cycles plus DEBOUNCE_TICKS ticks (edge on tick boundary: exactly DEBOUNCE_TICKS ticks after synchronised level arrives).
- held falling edge in cycle N → pending in N+1 → pushed N+1 (if lowest) → evt_valid=1 in N+2 when FIFO was empty.
- Simultaneous releases: pushed one per cycle in ascending key index.
- Press and release of different keys in same cycle: independent.
- fifo_count updates the cycle after push/pop; equals FIFO_DEPTH when full.
- evt_* stable while evt_valid && !evt_ready.

## Structure
- Package note_rec_pkg: note_evt_t struct {key, start, dur}, KEY_NONE = 0, function tick_div(CLK_HZ, TICK_HZ).
- Sub-module note_event_fifo: parametrised synchronous show-ahead FIFO of note_evt_t with count, full, empty.
- Debouncer and arbiter inline (generate loop per key).

## Test plan
Bench uses CLK_HZ=1000, TICK_HZ=100 (tick every 10 cycles), DEBOUNCE_TICKS=2.
- Reset, run 200 cycles → system_time=20, all other outputs 0.
- Press key 2 at time 5, release at time 40, evt_ready=1 → one record {2, 7, 35} (start/release each delayed 2 ticks debounce).
- Glitch key 1 low for 1 tick → held stays 0, no record.
- Keys 1 and 3 released on same tick → records key 1 then key 3 in consecutive cycles.
- evt_ready=0, release 9 notes → fifo_count=8, overflow=1, first 8 records intact; clear → count 0, overflow 0.
- Hold key 1 for 300 ticks → evt_dur=255; start near 2^14−1 with short hold → duration correct across wrap.
